// File: rtl/pkt_ctr_pkg.sv
// Shared definitions for the gated edge counter: edge-mode codes, FSM encoding
// and the increment/saturate rule applied to every channel counter.
package pkt_ctr_pkg;

    localparam logic [1:0] EM_FALL = 2'b00;
    localparam logic [1:0] EM_RISE = 2'b01;
    localparam logic [1:0] EM_BOTH = 2'b10;
    localparam logic [1:0] EM_NONE = 2'b11;

    // Widest counter the shared increment helper handles
    localparam int unsigned MAX_CW = 64;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ARM   = 2'b01,
        ST_COUNT = 2'b10,
        ST_LATCH = 2'b11
    } state_t;

    // count+1, or hold/wrap when count is already at max_val
    function automatic logic [MAX_CW-1:0] sat_inc(
        input logic [MAX_CW-1:0] count,
        input logic [MAX_CW-1:0] max_val,
        input logic              sat
    );
        if (count == max_val) begin
            return sat ? max_val : '0;
        end
        return count + MAX_CW'(1);
    endfunction

endpackage

// File: rtl/edge_det_sync.sv
// Per-channel input path: synchroniser chain, history flop and edge select.
// pulse is combinational from the last sync flop and the history flop.
module edge_det_sync
    import pkt_ctr_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sig,
    input  logic [1:0] edge_mode,
    output logic       pulse
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;
    logic                   cur;

    assign cur = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sig};
            hist_q <= cur;
        end
    end

    always_comb begin
        pulse = 1'b0;
        case (edge_mode)
            EM_FALL: pulse = ~cur & hist_q;
            EM_RISE: pulse = cur & ~hist_q;
            EM_BOTH: pulse = cur ^ hist_q;
            default: pulse = 1'b0;
        endcase
    end

endmodule

// File: rtl/gated_edge_ctr.sv
// Multi-channel gated edge counter: counts selected edges over a programmed
// window, then latches all channel counts into a snapshot and pulses done.
module gated_edge_ctr
    import pkt_ctr_pkg::*;
#(
    parameter int unsigned NCH         = 4,
    parameter int unsigned CW          = 32,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned SAT         = 0,
    // window counter width; defaults to CW, wider values let small counters overflow
    parameter int unsigned WW          = CW
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NCH-1:0]    sig,
    input  logic [1:0]        edge_mode,
    input  logic [WW-1:0]     win_len,
    input  logic              start,
    input  logic              clr,
    output logic              busy,
    output logic              done,
    output logic [NCH*CW-1:0] cnt_snap,
    output logic [NCH-1:0]    ovf
);

    localparam logic [CW-1:0] CNT_MAX = '1;
    localparam logic          SAT_EN  = 1'(SAT != 0);

    state_t          state;
    state_t          state_nxt;
    logic [1:0]      mode_q;
    logic [WW-1:0]   win_q;
    logic [WW-1:0]   remain_q;
    logic [NCH-1:0]  pulse;
    logic [CW-1:0]   live_q [NCH];
    logic            capture_c;
    logic            arm_c;
    logic            count_c;
    logic            latch_c;

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        edge_det_sync #(
            .SYNC_STAGES(SYNC_STAGES)
        ) u_det (
            .clk       (clk),
            .rst_n     (rst_n),
            .sig       (sig[i]),
            .edge_mode (mode_q),
            .pulse     (pulse[i])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // clr wins over every transition, including a start in IDLE
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (start) state_nxt = ST_ARM;
            ST_ARM:   state_nxt = ST_COUNT;
            ST_COUNT: if (remain_q == WW'(1)) state_nxt = ST_LATCH;
            ST_LATCH: state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
        if (clr) begin
            state_nxt = ST_IDLE;
        end
    end

    always_comb begin
        capture_c = 1'b0;
        arm_c     = 1'b0;
        count_c   = 1'b0;
        latch_c   = 1'b0;
        case (state)
            ST_IDLE:  capture_c = start & ~clr;
            ST_ARM:   arm_c     = ~clr;
            ST_COUNT: count_c   = ~clr;
            ST_LATCH: latch_c   = ~clr;
            default:  ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= ~clr & (state_nxt != ST_IDLE);
            done <= latch_c;
        end
    end

    // Window configuration and remaining-cycle down-counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q   <= EM_FALL;
            win_q    <= '0;
            remain_q <= '0;
        end else begin
            if (capture_c) begin
                mode_q <= edge_mode;
                win_q  <= win_len;
            end
            if (arm_c) begin
                remain_q <= (win_q == '0) ? WW'(1) : win_q;
            end else if (count_c) begin
                remain_q <= remain_q - WW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NCH; i++) live_q[i] <= '0;
            ovf <= '0;
        end else if (clr || arm_c) begin
            for (int i = 0; i < NCH; i++) live_q[i] <= '0;
            ovf <= '0;
        end else if (count_c) begin
            for (int i = 0; i < NCH; i++) begin
                if (pulse[i]) begin
                    live_q[i] <= CW'(sat_inc(MAX_CW'(live_q[i]), MAX_CW'(CNT_MAX), SAT_EN));
                    if (live_q[i] == CNT_MAX) ovf[i] <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_snap <= '0;
        end else if (clr) begin
            cnt_snap <= '0;
        end else if (latch_c) begin
            for (int i = 0; i < NCH; i++) cnt_snap[i*CW +: CW] <= live_q[i];
        end
    end

endmodule

// File: tb/tb_gated_edge_ctr.sv
// Bench for gated_edge_ctr: a 32-bit instance plus 4-bit saturating and
// wrapping instances share all stimulus; done snapshots go through a scoreboard.
module tb_gated_edge_ctr;
    import pkt_ctr_pkg::*;

    typedef struct {
        logic [127:0] snap;
        logic [3:0]   ovf;
        logic         busy;
        int           cyc;
    } obs_t;

    typedef struct {
        logic [3:0][31:0] cnt;
        int               cyc;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [3:0]   sig;
    logic [1:0]   edge_mode;
    logic [31:0]  win_len;
    logic [7:0]   win8;
    logic         start;
    logic         clr;
    logic         busy_m, done_m, busy_s, done_s, busy_w, done_w;
    logic [127:0] snap_m;
    logic [15:0]  snap_s, snap_w;
    logic [3:0]   ovf_m, ovf_s, ovf_w;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   hp [4];
    int   ph [4];
    obs_t obs_m [$];
    obs_t obs_s [$];
    obs_t obs_w [$];
    exp_t exp_q [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    gated_edge_ctr #(.NCH(4), .CW(32), .SYNC_STAGES(2), .SAT(0)) u_main (
        .clk(clk), .rst_n(rst_n), .sig(sig), .edge_mode(edge_mode), .win_len(win_len),
        .start(start), .clr(clr), .busy(busy_m), .done(done_m), .cnt_snap(snap_m), .ovf(ovf_m));

    gated_edge_ctr #(.NCH(4), .CW(4), .SYNC_STAGES(2), .SAT(1), .WW(8)) u_sat (
        .clk(clk), .rst_n(rst_n), .sig(sig), .edge_mode(edge_mode), .win_len(win8),
        .start(start), .clr(clr), .busy(busy_s), .done(done_s), .cnt_snap(snap_s), .ovf(ovf_s));

    gated_edge_ctr #(.NCH(4), .CW(4), .SYNC_STAGES(2), .SAT(0), .WW(8)) u_wrap (
        .clk(clk), .rst_n(rst_n), .sig(sig), .edge_mode(edge_mode), .win_len(win8),
        .start(start), .clr(clr), .busy(busy_w), .done(done_w), .cnt_snap(snap_w), .ovf(ovf_w));

    always @(negedge clk) begin
        if (done_m) obs_m.push_back('{snap_m, ovf_m, busy_m, cyc});
        if (done_s) obs_s.push_back('{128'(snap_s), ovf_s, busy_s, cyc});
        if (done_w) obs_w.push_back('{128'(snap_w), ovf_w, busy_w, cyc});
    end

    function automatic bit toggles(int ch, int t, int n);
        if (hp[ch] > 0) return (t <= n + 1) && ((t + ph[ch]) % hp[ch] == 0);
        if (hp[ch] < 0) return t == ph[ch];
        return 1'b0;
    endfunction

    function automatic bit counts(logic [1:0] mode, logic v);
        case (mode)
            EM_FALL: return !v;
            EM_RISE: return v;
            EM_BOTH: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Drives one window; an edge driven before posedge E0+t counts iff 0 <= t < n
    task automatic run_window(input string tag, input logic [1:0] mode, input int win,
                              input int restart_at);
        int          n;
        int          c0;
        exp_t        e;
        obs_t        om, os, ow;
        logic [31:0] nn;
        logic [3:0]  sv, wv;
        logic        ov;
        n = (win == 0) ? 1 : win;
        c0 = 0;
        e.cnt = '0;
        for (int t = 0; t < n + 4; t++) begin
            @(negedge clk);
            if (t == 0) begin
                c0 = cyc;
                start = 1'b1; edge_mode = mode; win_len = 32'(win); win8 = 8'(win);
            end else begin
                start = (t == restart_at);
                edge_mode = 2'($urandom);
                win_len = 32'($urandom_range(0, 3));
                win8 = 8'(win_len);
            end
            for (int ch = 0; ch < 4; ch++) begin
                if (toggles(ch, t, n)) begin
                    sig[ch] = ~sig[ch];
                    if (t < n && counts(mode, sig[ch])) e.cnt[ch] = e.cnt[ch] + 32'd1;
                end
            end
            if (t == 1) begin
                checks++;
                if (busy_m !== 1'b1) begin errors++; $display("FAIL %s busy: got %b want 1", tag, busy_m); end
            end
        end
        start = 1'b0;
        e.cyc = c0 + n + 3;
        exp_q.push_back(e);
        repeat (4) @(negedge clk);
        e = exp_q.pop_front();
        checks++;
        if (obs_m.size() != 1 || obs_s.size() != 1 || obs_w.size() != 1) begin
            errors++;
            $display("FAIL %s done_pulses: got %0d/%0d/%0d want 1/1/1", tag, obs_m.size(), obs_s.size(), obs_w.size());
            obs_m.delete(); obs_s.delete(); obs_w.delete();
        end else begin
            om = obs_m.pop_front(); os = obs_s.pop_front(); ow = obs_w.pop_front();
            checks++;
            if (om.cyc !== e.cyc) begin errors++; $display("FAIL %s done_cycle: got %0d want %0d", tag, om.cyc, e.cyc); end
            checks++;
            if (om.busy !== 1'b0) begin errors++; $display("FAIL %s busy_at_done: got %b want 0", tag, om.busy); end
            for (int ch = 0; ch < 4; ch++) begin
                nn = e.cnt[ch];
                sv = (nn > 32'd15) ? 4'd15 : 4'(nn);
                wv = 4'(nn);
                ov = (nn >= 32'd16);
                checks++;
                if (om.snap[ch*32 +: 32] !== nn) begin errors++;
                    $display("FAIL %s ch%0d cnt: got %0d want %0d", tag, ch, om.snap[ch*32 +: 32], nn); end
                checks++;
                if (om.ovf[ch] !== 1'b0) begin errors++; $display("FAIL %s ch%0d ovf: got %b want 0", tag, ch, om.ovf[ch]); end
                checks++;
                if (os.snap[ch*4 +: 4] !== sv) begin errors++;
                    $display("FAIL %s ch%0d sat_cnt: got %0d want %0d", tag, ch, os.snap[ch*4 +: 4], sv); end
                checks++;
                if (os.ovf[ch] !== ov) begin errors++; $display("FAIL %s ch%0d sat_ovf: got %b want %b", tag, ch, os.ovf[ch], ov); end
                checks++;
                if (ow.snap[ch*4 +: 4] !== wv) begin errors++;
                    $display("FAIL %s ch%0d wrap_cnt: got %0d want %0d", tag, ch, ow.snap[ch*4 +: 4], wv); end
                checks++;
                if (ow.ovf[ch] !== ov) begin errors++; $display("FAIL %s ch%0d wrap_ovf: got %b want %b", tag, ch, ow.ovf[ch], ov); end
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; sig = '0; edge_mode = EM_RISE; win_len = '0; win8 = '0; start = 1'b0; clr = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (busy_m !== 1'b0) begin errors++; $display("FAIL reset busy: got %b want 0", busy_m); end
        checks++; if (done_m !== 1'b0) begin errors++; $display("FAIL reset done: got %b want 0", done_m); end
        checks++; if (snap_m !== '0) begin errors++; $display("FAIL reset snap: got %h want 0", snap_m); end
        checks++; if (ovf_m !== '0 || ovf_s !== '0) begin errors++; $display("FAIL reset ovf: got %b/%b want 0", ovf_m, ovf_s); end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_rising;
        hp = '{4, 0, 0, 0};
        ph = '{int'($urandom_range(0, 3)), 0, 0, 0};
        run_window("rise100", EM_RISE, 100, -1);
    endtask

    task automatic test_edge_modes;
        hp = '{0, 0, 2, 3};
        ph = '{0, 0, 0, 1};
        run_window("both16", EM_BOTH, 16, -1);
        run_window("fall16", EM_FALL, 16, -1);
        run_window("none16", EM_NONE, 16, -1);
    endtask

    task automatic test_saturate;
        hp = '{1, 2, 0, 0};
        ph = '{0, 0, 0, 0};
        run_window("ovf40", EM_RISE, 40, -1);
        hp = '{1, 0, 0, 0};
        run_window("after_ovf", EM_RISE, 6, -1);
    endtask

    task automatic test_control;
        hp = '{3, 0, 0, 0};
        ph = '{0, 0, 0, 0};
        run_window("restart", EM_RISE, 20, 6);
        // clr together with start mid-window: abort, nothing restarts
        @(negedge clk);
        start = 1'b1; edge_mode = EM_BOTH; win_len = 32'd30; win8 = 8'd30;
        @(negedge clk);
        start = 1'b0;
        repeat (8) begin @(negedge clk); sig[1] = ~sig[1]; end
        clr = 1'b1; start = 1'b1;
        @(negedge clk);
        clr = 1'b0; start = 1'b0;
        checks++; if (busy_m !== 1'b0) begin errors++; $display("FAIL clr busy: got %b want 0", busy_m); end
        checks++; if (snap_m !== '0 || snap_s !== '0) begin errors++; $display("FAIL clr snap: got %h/%h want 0", snap_m, snap_s); end
        checks++; if (ovf_m !== '0 || ovf_w !== '0) begin errors++; $display("FAIL clr ovf: got %b/%b want 0", ovf_m, ovf_w); end
        @(negedge clk);
        checks++; if (busy_m !== 1'b0) begin errors++; $display("FAIL clr_start busy: got %b want 0", busy_m); end
        repeat (40) @(negedge clk);
        checks++;
        if (obs_m.size() != 0) begin errors++; $display("FAIL clr no_done: got %0d pulses want 0", obs_m.size()); end
        obs_m.delete(); obs_s.delete(); obs_w.delete();
        hp = '{1, -1, 0, 0};
        ph = '{0, 1, 0, 0};
        run_window("win0", EM_BOTH, 0, -1);
    endtask

    task automatic test_boundary;
        sig = '0;
        repeat (6) @(negedge clk);
        hp = '{-1, -1, -1, 0};
        ph = '{9, 10, 0, 0};
        run_window("boundary", EM_RISE, 10, -1);
    endtask

    task automatic test_reset_mid;
        @(negedge clk);
        start = 1'b1; edge_mode = EM_RISE; win_len = 32'd60; win8 = 8'd60;
        @(negedge clk);
        start = 1'b0;
        repeat (10) begin @(negedge clk); sig[0] = ~sig[0]; end
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++; if (busy_m !== 1'b0) begin errors++; $display("FAIL rst_mid busy: got %b want 0", busy_m); end
        checks++; if (done_m !== 1'b0) begin errors++; $display("FAIL rst_mid done: got %b want 0", done_m); end
        checks++; if (snap_m !== '0) begin errors++; $display("FAIL rst_mid snap: got %h want 0", snap_m); end
        checks++; if (ovf_m !== '0) begin errors++; $display("FAIL rst_mid ovf: got %b want 0", ovf_m); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (80) @(negedge clk);
        checks++;
        if (obs_m.size() != 0 || busy_m !== 1'b0) begin errors++;
            $display("FAIL rst_mid no_done: got %0d pulses busy %b want 0 0", obs_m.size(), busy_m); end
    endtask

    initial begin
        test_reset();
        test_rising();
        test_edge_modes();
        test_saturate();
        test_control();
        test_boundary();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
